// File: rtl/instr_fetch_seq.sv
// Instruction-fetch sequencer: holds the PC, fetches from a combinational ROM, issues to the core.
// Latency: start_i to first instr_valid_o is 2 cycles; one instruction per 2 cycles when the core does not stall.
// Backpressure: stall_i holds the issued instruction, the PC and the retire count until the core accepts.
module instr_fetch_seq #(
    parameter logic [7:0] HALT_OPC    = 8'b10001000,
    parameter logic [7:0] ILLEGAL_OPC = 8'hFF,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [7:0]       start_addr_i,
    output logic [7:0]       rom_addr_o,
    input  logic [7:0]       rom_data_i,
    output logic [7:0]       instr_o,
    output logic [7:0]       instr_pc_o,
    output logic             instr_valid_o,
    input  logic             stall_i,
    input  logic             branch_taken_i,
    input  logic [7:0]       branch_off_i,
    output logic             done_o,
    output logic             error_o,
    output logic [CNT_W-1:0] retired_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        ISSUE  = 3'd2,
        HALTED = 3'd3,
        ERROR  = 3'd4
    } state_t;

    state_t           state_q;
    logic [7:0]       pc_q;
    logic [7:0]       instr_q;
    logic [7:0]       instr_pc_q;
    logic             valid_q;
    logic             done_q;
    logic             error_q;
    logic [CNT_W-1:0] retired_q;

    logic [7:0]       pc_ret_d;
    logic [CNT_W-1:0] retired_d;

    // Next PC once the issued instruction retires; branches only redirect when taken, mod-256 arithmetic.
    always_comb begin
        pc_ret_d = instr_pc_q + 8'd1;
        if (branch_taken_i) begin
            if (instr_q[7:3] == 5'b11110) begin
                pc_ret_d = instr_pc_q + 8'd1 + branch_off_i;
            end else if (instr_q[7:3] == 5'b10110) begin
                pc_ret_d = instr_pc_q + 8'd1 - branch_off_i;
            end
        end
        retired_d = (&retired_q) ? retired_q : retired_q + CNT_W'(1);
    end

    // Sequencer FSM with registered outputs; reset aborts any pending redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= 8'd0;
            instr_q    <= 8'd0;
            instr_pc_q <= 8'd0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            retired_q  <= '0;
        end else begin
            case (state_q)
                IDLE, HALTED, ERROR: begin
                    if (start_i) begin
                        pc_q      <= start_addr_i;
                        retired_q <= '0;
                        done_q    <= 1'b0;
                        error_q   <= 1'b0;
                        state_q   <= FETCH;
                    end
                end
                FETCH: begin
                    instr_q    <= rom_data_i;
                    instr_pc_q <= pc_q;
                    valid_q    <= 1'b1;
                    state_q    <= ISSUE;
                end
                ISSUE: begin
                    if (!stall_i) begin
                        valid_q <= 1'b0;
                        if (instr_q == HALT_OPC) begin
                            retired_q <= retired_d;
                            done_q    <= 1'b1;
                            state_q   <= HALTED;
                        end else if (instr_q == ILLEGAL_OPC) begin
                            error_q <= 1'b1;
                            state_q <= ERROR;
                        end else begin
                            retired_q <= retired_d;
                            pc_q      <= pc_ret_d;
                            state_q   <= FETCH;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rom_addr_o    = pc_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = valid_q;
    assign done_o        = done_q;
    assign error_o       = error_q;
    assign retired_o     = retired_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
module tb_instr_fetch_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [7:0]  start_addr_i = 8'd0;
    logic [7:0]  rom_addr_o;
    logic [7:0]  rom_data_i;
    logic [7:0]  instr_o;
    logic [7:0]  instr_pc_o;
    logic        instr_valid_o;
    logic        stall_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [7:0]  branch_off_i = 8'd0;
    logic        done_o;
    logic        error_o;
    logic [15:0] retired_o;

    logic [7:0]  rom [256];
    int          n_chk = 0;
    int          n_fail = 0;

    assign rom_data_i = rom[rom_addr_o];

    always #5 clk = ~clk;

    instr_fetch_seq dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start_i),
        .start_addr_i   (start_addr_i),
        .rom_addr_o     (rom_addr_o),
        .rom_data_i     (rom_data_i),
        .instr_o        (instr_o),
        .instr_pc_o     (instr_pc_o),
        .instr_valid_o  (instr_valid_o),
        .stall_i        (stall_i),
        .branch_taken_i (branch_taken_i),
        .branch_off_i   (branch_off_i),
        .done_o         (done_o),
        .error_o        (error_o),
        .retired_o      (retired_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start_i = 1'b0;
        stall_i = 1'b0;
        branch_taken_i = 1'b0;
        branch_off_i = 8'd0;
        tick();
        reset = 1'b0;
    endtask

    // Pulse start and step through FETCH; returns with the DUT in ISSUE.
    task automatic launch(input logic [7:0] addr);
        start_addr_i = addr;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        tick();
        do_reset();
        n_chk++;
        if ({rom_addr_o, instr_o, instr_pc_o, instr_valid_o, done_o, error_o, retired_o} !== 43'd0) begin
            n_fail++;
            $display("FAIL reset_state: addr=%0d instr=%h pc=%0d vld=%b done=%b err=%b ret=%0d, want all 0",
                     rom_addr_o, instr_o, instr_pc_o, instr_valid_o, done_o, error_o, retired_o);
        end
    endtask

    task automatic test_basic();
        do_reset();
        rom[0] = 8'hC1;
        rom[1] = 8'h05;
        start_addr_i = 8'd0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n_chk++;
        if ({instr_valid_o, rom_addr_o} !== {1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL basic_fetch: vld=%b addr=%0d, want vld=0 addr=0", instr_valid_o, rom_addr_o);
        end
        tick();
        n_chk++;
        if ({instr_valid_o, instr_o, instr_pc_o} !== {1'b1, 8'hC1, 8'd0}) begin
            n_fail++;
            $display("FAIL basic_issue: vld=%b instr=%h pc=%0d, want vld=1 instr=c1 pc=0",
                     instr_valid_o, instr_o, instr_pc_o);
        end
        tick();
        n_chk++;
        if ({instr_valid_o, rom_addr_o, retired_o} !== {1'b0, 8'd1, 16'd1}) begin
            n_fail++;
            $display("FAIL basic_next: vld=%b addr=%0d ret=%0d, want vld=0 addr=1 ret=1",
                     instr_valid_o, rom_addr_o, retired_o);
        end
        tick();
        n_chk++;
        if ({instr_valid_o, instr_o, instr_pc_o} !== {1'b1, 8'h05, 8'd1}) begin
            n_fail++;
            $display("FAIL basic_second: vld=%b instr=%h pc=%0d, want vld=1 instr=05 pc=1",
                     instr_valid_o, instr_o, instr_pc_o);
        end
    endtask

    task automatic test_branch_fwd();
        do_reset();
        rom[17] = 8'hF7;
        launch(8'd17);
        branch_taken_i = 1'b1;
        branch_off_i = 8'd8;
        tick();
        n_chk++;
        if (rom_addr_o !== 8'd26) begin
            n_fail++;
            $display("FAIL fwd_taken: addr=%0d, want 26", rom_addr_o);
        end
        do_reset();
        launch(8'd17);
        branch_taken_i = 1'b0;
        branch_off_i = 8'd8;
        tick();
        n_chk++;
        if (rom_addr_o !== 8'd18) begin
            n_fail++;
            $display("FAIL fwd_not_taken: addr=%0d, want 18", rom_addr_o);
        end
    endtask

    task automatic test_branch_back();
        do_reset();
        rom[49] = 8'hB6;
        launch(8'd49);
        branch_taken_i = 1'b1;
        branch_off_i = 8'd38;
        tick();
        n_chk++;
        if (rom_addr_o !== 8'd12) begin
            n_fail++;
            $display("FAIL back_taken: addr=%0d, want 12", rom_addr_o);
        end
        do_reset();
        rom[3] = 8'hB7;
        launch(8'd3);
        branch_taken_i = 1'b1;
        branch_off_i = 8'd10;
        tick();
        n_chk++;
        if (rom_addr_o !== 8'd250) begin
            n_fail++;
            $display("FAIL back_wrap: addr=%0d, want 250", rom_addr_o);
        end
        branch_taken_i = 1'b0;
    endtask

    task automatic test_halt();
        do_reset();
        rom[98] = 8'h00;
        rom[99] = 8'h88;
        rom[100] = 8'h01;
        launch(8'd98);
        tick();
        tick();
        n_chk++;
        if ({instr_valid_o, instr_o, done_o} !== {1'b1, 8'h88, 1'b0}) begin
            n_fail++;
            $display("FAIL halt_issue: vld=%b instr=%h done=%b, want vld=1 instr=88 done=0",
                     instr_valid_o, instr_o, done_o);
        end
        tick();
        n_chk++;
        if ({done_o, instr_valid_o, retired_o} !== {1'b1, 1'b0, 16'd2}) begin
            n_fail++;
            $display("FAIL halt_done: done=%b vld=%b ret=%0d, want done=1 vld=0 ret=2",
                     done_o, instr_valid_o, retired_o);
        end
        tick();
        n_chk++;
        if ({done_o, instr_valid_o, retired_o} !== {1'b1, 1'b0, 16'd2}) begin
            n_fail++;
            $display("FAIL halt_hold: done=%b vld=%b ret=%0d, want done=1 vld=0 ret=2",
                     done_o, instr_valid_o, retired_o);
        end
        start_addr_i = 8'd100;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n_chk++;
        if ({done_o, rom_addr_o, retired_o} !== {1'b0, 8'd100, 16'd0}) begin
            n_fail++;
            $display("FAIL halt_restart: done=%b addr=%0d ret=%0d, want done=0 addr=100 ret=0",
                     done_o, rom_addr_o, retired_o);
        end
        tick();
        n_chk++;
        if ({instr_valid_o, instr_o, instr_pc_o} !== {1'b1, 8'h01, 8'd100}) begin
            n_fail++;
            $display("FAIL halt_restart_issue: vld=%b instr=%h pc=%0d, want vld=1 instr=01 pc=100",
                     instr_valid_o, instr_o, instr_pc_o);
        end
    endtask

    task automatic test_stall();
        do_reset();
        rom[120] = 8'hF0;
        launch(8'd120);
        stall_i = 1'b1;
        branch_taken_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            branch_off_i = 8'(i * 7 + 1);
            start_addr_i = 8'd7;
            start_i = 1'b1;
            tick();
            n_chk++;
            if ({instr_valid_o, instr_o, instr_pc_o, rom_addr_o, retired_o} !== {1'b1, 8'hF0, 8'd120, 8'd120, 16'd0}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: vld=%b instr=%h pc=%0d addr=%0d ret=%0d, want 1 f0 120 120 0",
                         i, instr_valid_o, instr_o, instr_pc_o, rom_addr_o, retired_o);
            end
        end
        start_i = 1'b0;
        stall_i = 1'b0;
        branch_off_i = 8'd4;
        tick();
        n_chk++;
        if ({rom_addr_o, retired_o} !== {8'd125, 16'd1}) begin
            n_fail++;
            $display("FAIL stall_release: addr=%0d ret=%0d, want addr=125 ret=1", rom_addr_o, retired_o);
        end
        branch_taken_i = 1'b0;
    endtask

    task automatic test_illegal_wrap();
        do_reset();
        rom[255] = 8'hFF;
        launch(8'd255);
        tick();
        n_chk++;
        if ({error_o, instr_valid_o, retired_o} !== {1'b1, 1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL illegal: err=%b vld=%b ret=%0d, want err=1 vld=0 ret=0",
                     error_o, instr_valid_o, retired_o);
        end
        rom[255] = 8'h10;
        launch(8'd255);
        n_chk++;
        if ({error_o, instr_valid_o, instr_o} !== {1'b0, 1'b1, 8'h10}) begin
            n_fail++;
            $display("FAIL err_restart: err=%b vld=%b instr=%h, want err=0 vld=1 instr=10",
                     error_o, instr_valid_o, instr_o);
        end
        branch_taken_i = 1'b1;
        branch_off_i = 8'd5;
        tick();
        n_chk++;
        if ({rom_addr_o, retired_o} !== {8'd0, 16'd1}) begin
            n_fail++;
            $display("FAIL wrap_255: addr=%0d ret=%0d, want addr=0 ret=1", rom_addr_o, retired_o);
        end
        do_reset();
        rom[60] = 8'hF1;
        launch(8'd60);
        branch_taken_i = 1'b1;
        branch_off_i = 8'd0;
        tick();
        n_chk++;
        if (rom_addr_o !== 8'd61) begin
            n_fail++;
            $display("FAIL off_zero: addr=%0d, want 61", rom_addr_o);
        end
        branch_taken_i = 1'b0;
    endtask

    task automatic test_reset_mid_issue();
        do_reset();
        rom[17] = 8'hF7;
        launch(8'd17);
        branch_taken_i = 1'b1;
        branch_off_i = 8'd8;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_chk++;
        if ({rom_addr_o, instr_o, instr_pc_o, instr_valid_o, done_o, error_o, retired_o} !== 43'd0) begin
            n_fail++;
            $display("FAIL reset_mid: addr=%0d instr=%h pc=%0d vld=%b done=%b err=%b ret=%0d, want all 0",
                     rom_addr_o, instr_o, instr_pc_o, instr_valid_o, done_o, error_o, retired_o);
        end
        tick();
        tick();
        n_chk++;
        if ({rom_addr_o, instr_valid_o} !== {8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_idle: addr=%0d vld=%b, want addr=0 vld=0", rom_addr_o, instr_valid_o);
        end
        branch_taken_i = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = 8'hFF;
        test_reset();
        test_basic();
        test_branch_fwd();
        test_branch_back();
        test_halt();
        test_stall();
        test_illegal_wrap();
        test_reset_mid_issue();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
- Instruction-fetch sequencer; the reading side of the program ROM (8-bit address out, 8-bit instruction in, combinational ROM).
- Holds the PC and fetches one instruction at a time.
- Presents each instruction to the core with a valid/stall handshake.
- Resolves branch/branchb redirects, detects halt and illegal fetches, and counts retired instructions.

Parameters:
- HALT_OPC, 8'b10001000, opcode that stops the sequencer.
- ILLEGAL_OPC, 8'hFF, ROM default fill; fetching it is an error.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start_i  in  1  begin execution at start_addr_i (sampled in IDLE, HALTED, ERROR).
- start_addr_i  in  8  program entry address (0, 100, 152 for programs 1-3).
- rom_addr_o  out  8  address to ROM; equals PC.
- rom_data_i  in  8  instruction from ROM.
- instr_o  out  8  registered instruction for the core.
- instr_pc_o  out  8  address instr_o was fetched from.
- instr_valid_o  out  1  instr_o valid (ISSUE state).
- stall_i  in  1  core not ready; hold current issue.
- branch_taken_i  in  1  core flag result for the branch in instr_o; sampled only in ISSUE.
- branch_off_i  in  8  unsigned branch distance (register value) for that branch.
- done_o  out  1  halt reached.
- error_o  out  1  illegal opcode fetched.
- retired_o  out  CNT_W  instructions retired since start.

Behaviour:
Reset:
- State IDLE; PC=0; instr_o=0; instr_pc_o=0.
- instr_valid_o=0, done_o=0, error_o=0, retired_o=0.
- Reset mid-operation aborts immediately; no pending branch is honoured.

rom_addr_o:
- Always = PC (combinational from the PC register).

States:
- IDLE:
  - start_i=1 -> PC<=start_addr_i, retired_o<=0, go FETCH.
- FETCH (1 cycle):
  - instr_o<=rom_data_i, instr_pc_o<=PC.
  - Go ISSUE.
- ISSUE:
  - instr_valid_o=1.
  - stall_i=1: hold everything; instr_o, instr_pc_o and PC are stable; branch inputs are ignored.
  - stall_i=0: instruction retires this cycle; retired_o += 1, saturating at all-ones. Then, by priority:
    - instr_o==HALT_OPC -> done_o<=1, go HALTED (halt counts as retired).
    - instr_o==ILLEGAL_OPC -> error_o<=1, go ERROR (not counted as retired).
    - instr_o[7:3]==5'b11110 (branch fwd) and branch_taken_i -> PC<=instr_pc_o+1+branch_off_i.
    - instr_o[7:3]==5'b10110 (branchb) and branch_taken_i -> PC<=instr_pc_o+1-branch_off_i.
    - otherwise -> PC<=instr_pc_o+1.
    - Except for HALTED and ERROR, go FETCH.
- HALTED / ERROR:
  - instr_valid_o=0; done_o/error_o held.
  - start_i=1 -> clear done_o/error_o/retired_o, PC<=start_addr_i, go FETCH.

Timing and arithmetic:
- Throughput: one instruction per 2 cycles without stalls.
- Latency from start_i to first instr_valid_o: 2 cycles.
- All PC arithmetic is mod 256. Address 255 +1 wraps to 0; branch targets wrap both directions.
- branch_taken_i is ignored for non-branch opcodes.
- branch_off_i=0 taken behaves as fall-through.
- start_i in FETCH/ISSUE is ignored.
- instr_valid_o=0 in all states except ISSUE.

Test Plan:
1. Start with start_addr_i=0, ROM word 0 = 8'hC1, no stalls -> rom_addr_o=0. Two cycles later instr_valid_o=1, instr_o=8'hC1, instr_pc_o=0. Next FETCH uses rom_addr_o=1. retired_o=1 after the issue.
2. Forward branch: instr 8'hF7 at 17, branch_taken_i=1, branch_off_i=8 -> next rom_addr_o=26. Same with branch_taken_i=0 -> 18.
3. Backward branch: 8'hB6 at 49, taken, off=38 -> next fetch 12. Wrap case: 8'hB7 at 3, off=10 -> PC=250.
4. Halt at 99 (8'h88) -> done_o=1 the cycle after issue, instr_valid_o=0 thereafter, retired_o equals the issued count. start_i with start_addr_i=100 -> done_o=0, fetch from 100.
5. Stall: hold stall_i=1 for 5 cycles in ISSUE on a taken branch while toggling branch_off_i -> instr_o and PC are unchanged and retired_o does not increment. Release with off=4 -> redirect uses only the final values.
6. Illegal/wrap/reset:
   - Fetch at 255 returning 8'hFF -> error_o=1, retired_o unchanged.
   - Non-branch at 255 -> next PC=0.
   - Assert reset during ISSUE of a taken branch -> next cycle IDLE, all outputs 0, no redirect.
